// File: rtl/jtkcpu_pkg.sv
// jtkcpu_pkg
// Shared definitions for the KCPU register bank and EXG/TFR sequencer:
//   - 4-bit register codes used by postbytes and single-register loads
//   - EXG/TFR opcodes
//   - sequencer state encoding
//   - code_valid(): tells whether a register code names a real register
package jtkcpu_pkg;

  localparam logic [3:0] REG_D  = 4'h0;
  localparam logic [3:0] REG_X  = 4'h1;
  localparam logic [3:0] REG_Y  = 4'h2;
  localparam logic [3:0] REG_U  = 4'h3;
  localparam logic [3:0] REG_S  = 4'h4;
  localparam logic [3:0] REG_PC = 4'h5;
  localparam logic [3:0] REG_A  = 4'h8;
  localparam logic [3:0] REG_B  = 4'h9;
  localparam logic [3:0] REG_CC = 4'hA;
  localparam logic [3:0] REG_DP = 4'hB;

  localparam logic [7:0] OP_EXG = 8'h3E;
  localparam logic [7:0] OP_TFR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WR1,
    ST_WR2,
    ST_DONE
  } xfer_state_e;

  function automatic logic code_valid(input logic [3:0] code);
    case (code)
      REG_D, REG_X, REG_Y, REG_U, REG_S, REG_PC,
      REG_A, REG_B, REG_CC, REG_DP: code_valid = 1'b1;
      default:                      code_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jtkcpu_xfer_rdmux.sv
// jtkcpu_xfer_rdmux
// Combinational read of one register by its 4-bit code, widened to 16 bits.
// Ports:
//   sel_i                 register code
//   a_i, b_i, dp_i, cc_i  8-bit registers
//   x_i .. pc_i           16-bit registers
//   data_o                16-bit read value
// 8-bit registers read as {8'hFF, reg}; invalid codes read as 16'h0000.
module jtkcpu_xfer_rdmux
  import jtkcpu_pkg::*;
(
  input  logic [3:0]  sel_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  cc_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [15:0] u_i,
  input  logic [15:0] s_i,
  input  logic [15:0] pc_i,
  output logic [15:0] data_o
);

  always_comb begin
    data_o = 16'h0000;
    case (sel_i)
      REG_D:   data_o = {a_i, b_i};
      REG_X:   data_o = x_i;
      REG_Y:   data_o = y_i;
      REG_U:   data_o = u_i;
      REG_S:   data_o = s_i;
      REG_PC:  data_o = pc_i;
      REG_A:   data_o = {8'hFF, a_i};
      REG_B:   data_o = {8'hFF, b_i};
      REG_CC:  data_o = {8'hFF, cc_i};
      REG_DP:  data_o = {8'hFF, dp_i};
      default: data_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/jtkcpu_xfer_regs.sv
// jtkcpu_xfer_regs
// KCPU register bank (A, B, DP, CC, X, Y, U, S, PC) with an EXG/TFR
// write-back sequencer and a single-register load port.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, op, postbyte             transfer request (sampled in IDLE)
//   ld_we, ld_sel, ld_data          single-register load (IDLE only)
//   busy, done, bad                 sequencer status
//   a, b, dp, cc, x, y, u, s, pc    register contents
// Optional build macro JTKCPU_XFER_DBG_EN adds xfer_cnt[15:0] (completed
// transfers, wrapping) and last_pb[7:0] (postbyte of last completed one).
module jtkcpu_xfer_regs
  import jtkcpu_pkg::*;
#(
  parameter logic [7:0]  CC_RST = 8'h50,
  parameter logic [15:0] PC_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [7:0]  postbyte,
  input  logic        ld_we,
  input  logic [3:0]  ld_sel,
  input  logic [15:0] ld_data,
  output logic        busy,
  output logic        done,
  output logic        bad,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [7:0]  dp,
  output logic [7:0]  cc,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic [15:0] u,
  output logic [15:0] s,
`ifdef JTKCPU_XFER_DBG_EN
  output logic [15:0] pc,
  output logic [15:0] xfer_cnt,
  output logic [7:0]  last_pb
`else
  output logic [15:0] pc
`endif
);

  xfer_state_e state_q;
  logic [7:0]  op_q, pb_q;
  logic [15:0] tmp_src_q, tmp_dst_q;
  logic        done_q, bad_q;
  logic [15:0] src_rd, dst_rd;

  logic [7:0]  a_q, b_q, dp_q, cc_q, a_d, b_d, dp_d, cc_d;
  logic [15:0] x_q, y_q, u_q, s_q, pc_q, x_d, y_d, u_d, s_d, pc_d;

  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;

  jtkcpu_xfer_rdmux u_src_mux (
    .sel_i(pb_q[7:4]), .a_i(a_q), .b_i(b_q), .dp_i(dp_q), .cc_i(cc_q),
    .x_i(x_q), .y_i(y_q), .u_i(u_q), .s_i(s_q), .pc_i(pc_q), .data_o(src_rd)
  );

  jtkcpu_xfer_rdmux u_dst_mux (
    .sel_i(pb_q[3:0]), .a_i(a_q), .b_i(b_q), .dp_i(dp_q), .cc_i(cc_q),
    .x_i(x_q), .y_i(y_q), .u_i(u_q), .s_i(s_q), .pc_i(pc_q), .data_o(dst_rd)
  );

  // Only one writer per cycle: the load port in IDLE, WR1 to the destination,
  // WR2 back to the source. WR2 writing last is what settles D/A/B overlaps.
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = ld_sel;
    wr_data = ld_data;
    case (state_q)
      ST_IDLE: wr_en = ld_we;
      ST_WR1: begin
        wr_en   = 1'b1;
        wr_sel  = pb_q[3:0];
        wr_data = tmp_src_q;
      end
      ST_WR2: begin
        wr_en   = 1'b1;
        wr_sel  = pb_q[7:4];
        wr_data = tmp_dst_q;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  dp_d = dp_q;  cc_d = cc_q;
    x_d = x_q;  y_d = y_q;  u_d = u_q;    s_d = s_q;   pc_d = pc_q;
    if (wr_en) begin
      case (wr_sel)
        REG_D:   {a_d, b_d} = wr_data;
        REG_X:   x_d  = wr_data;
        REG_Y:   y_d  = wr_data;
        REG_U:   u_d  = wr_data;
        REG_S:   s_d  = wr_data;
        REG_PC:  pc_d = wr_data;
        REG_A:   a_d  = wr_data[7:0];
        REG_B:   b_d  = wr_data[7:0];
        REG_CC:  cc_d = wr_data[7:0];
        REG_DP:  dp_d = wr_data[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 8'h00;  b_q <= 8'h00;  dp_q <= 8'h00;  cc_q <= CC_RST;
      x_q <= 16'h0;  y_q <= 16'h0;  u_q <= 16'h0;   s_q <= 16'h0;  pc_q <= PC_RST;
    end else begin
      a_q <= a_d;  b_q <= b_d;  dp_q <= dp_d;  cc_q <= cc_d;
      x_q <= x_d;  y_q <= y_d;  u_q <= u_d;    s_q <= s_d;   pc_q <= pc_d;
    end
  end

  // done is registered out of DONE, so it is high in the first IDLE cycle;
  // start is held off for that cycle as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 8'h00;
      pb_q      <= 8'h00;
      tmp_src_q <= 16'h0000;
      tmp_dst_q <= 16'h0000;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !done_q) begin
            op_q    <= op;
            pb_q    <= postbyte;
            state_q <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          tmp_src_q <= src_rd;
          tmp_dst_q <= dst_rd;
          state_q   <= ST_WR1;
        end
        ST_WR1:  state_q <= (op_q == OP_EXG) ? ST_WR2 : ST_DONE;
        ST_WR2:  state_q <= ST_DONE;
        ST_DONE: begin
          done_q  <= 1'b1;
          bad_q   <= !code_valid(pb_q[7:4]) || !code_valid(pb_q[3:0]);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef JTKCPU_XFER_DBG_EN
  logic [15:0] xfer_cnt_q;
  logic [7:0]  last_pb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 16'h0000;
      last_pb_q  <= 8'h00;
    end else if (state_q == ST_DONE) begin
      xfer_cnt_q <= xfer_cnt_q + 16'h0001;
      last_pb_q  <= pb_q;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign last_pb  = last_pb_q;
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign bad  = bad_q;
  assign a  = a_q;   assign b  = b_q;   assign dp = dp_q;  assign cc = cc_q;
  assign x  = x_q;   assign y  = y_q;   assign u  = u_q;   assign s  = s_q;
  assign pc = pc_q;

endmodule

// File: tb/tb_jtkcpu_xfer_regs.sv
// tb_jtkcpu_xfer_regs
// Self-checking bench for jtkcpu_xfer_regs. A reference model of the register
// bank predicts each transfer; predictions are queued when a transfer is
// started and popped when the DUT pulses done.
module tb_jtkcpu_xfer_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ld_we;
  logic [7:0]  op, postbyte;
  logic [3:0]  ld_sel;
  logic [15:0] ld_data;
  logic        busy, done, bad;
  logic [7:0]  a, b, dp, cc;
  logic [15:0] x, y, u, s, pc;
`ifdef JTKCPU_XFER_DBG_EN
  logic [15:0] xfer_cnt;
  logic [7:0]  last_pb;
`endif

  int compared   = 0;
  int mismatched = 0;

  jtkcpu_xfer_regs dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .postbyte(postbyte),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_data(ld_data),
    .busy(busy), .done(done), .bad(bad),
    .a(a), .b(b), .dp(dp), .cc(cc), .x(x), .y(y), .u(u), .s(s),
`ifdef JTKCPU_XFER_DBG_EN
    .pc(pc), .xfer_cnt(xfer_cnt), .last_pb(last_pb)
`else
    .pc(pc)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  mA, mB, mDP, mCC;
  logic [15:0] mX, mY, mU, mS, mPC;
  int          mCnt;
  logic [7:0]  mLastPb;

  typedef struct {
    int         lat;
    logic       bad;
    logic [7:0] pb;
    logic [111:0] regs;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [111:0] dutRegs();
    return {a, b, dp, cc, x, y, u, s, pc};
  endfunction

  function automatic logic [111:0] modelRegs();
    return {mA, mB, mDP, mCC, mX, mY, mU, mS, mPC};
  endfunction

  function automatic logic isValid(input logic [3:0] c);
    return (c <= 4'h5) || (c >= 4'h8 && c <= 4'hB);
  endfunction

  function automatic logic [15:0] mRead(input logic [3:0] c);
    case (c)
      4'h0: return {mA, mB};
      4'h1: return mX;
      4'h2: return mY;
      4'h3: return mU;
      4'h4: return mS;
      4'h5: return mPC;
      4'h8: return {8'hFF, mA};
      4'h9: return {8'hFF, mB};
      4'hA: return {8'hFF, mCC};
      4'hB: return {8'hFF, mDP};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic mWrite(input logic [3:0] c, input logic [15:0] d);
    case (c)
      4'h0: begin mA = d[15:8]; mB = d[7:0]; end
      4'h1: mX = d;
      4'h2: mY = d;
      4'h3: mU = d;
      4'h4: mS = d;
      4'h5: mPC = d;
      4'h8: mA = d[7:0];
      4'h9: mB = d[7:0];
      4'hA: mCC = d[7:0];
      4'hB: mDP = d[7:0];
      default: ;
    endcase
  endtask

  task automatic mReset();
    mA = 8'h00; mB = 8'h00; mDP = 8'h00; mCC = 8'h50;
    mX = 16'h0; mY = 16'h0; mU = 16'h0; mS = 16'h0; mPC = 16'h0000;
    mCnt = 0; mLastPb = 8'h00;
  endtask

  // Single-register load; entered and left at a negedge.
  task automatic loadReg(input logic [3:0] sel, input logic [15:0] d);
    ld_we = 1'b1; ld_sel = sel; ld_data = d;
    @(posedge clk);
    @(negedge clk);
    ld_we = 1'b0;
    mWrite(sel, d);
  endtask

  // Starts a transfer, queues the prediction, waits for done and checks it.
  task automatic runXfer(input logic [7:0] o, input logic [7:0] pb);
    exp_t        e, got;
    logic [15:0] ts, td;
    int          n;
    bit          seen;
    ts = mRead(pb[7:4]);
    td = mRead(pb[3:0]);
    mWrite(pb[3:0], ts);
    if (o == 8'h3E) mWrite(pb[7:4], td);
    e.lat  = (o == 8'h3E) ? 4 : 3;
    e.bad  = !isValid(pb[7:4]) || !isValid(pb[3:0]);
    e.pb   = pb;
    e.regs = modelRegs();
    sbq.push_back(e);
    mCnt++; mLastPb = pb;

    start = 1'b1; op = o; postbyte = pb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL busy_after_start pb=%h got=%b want=1", pb, busy);
    end
    seen = 0;
    n = 0;
    while (!seen && n < 12) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1;
    end
    got = sbq.pop_front();
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL done_timeout pb=%h got=none want=done after %0d edges", pb, got.lat);
    end else begin
      if (n !== got.lat) begin
        mismatched++;
        $display("[TB] FAIL done_latency pb=%h got=%0d want=%0d", pb, n, got.lat);
      end
      compared++;
      if (bad !== got.bad) begin
        mismatched++;
        $display("[TB] FAIL bad_flag pb=%h got=%b want=%b", pb, bad, got.bad);
      end
      compared++;
      if (dutRegs() !== got.regs) begin
        mismatched++;
        $display("[TB] FAIL regs pb=%h got=%h want=%h", pb, dutRegs(), got.regs);
      end
    end
    // done is high in this cycle; start would not be taken until the next one
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; ld_we = 1'b0; op = 8'h00; postbyte = 8'h00;
    ld_sel = 4'h0; ld_data = 16'h0;
    mReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compared++;
    if (dutRegs() !== {8'h00, 8'h00, 8'h00, 8'h50, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}) begin
      mismatched++;
      $display("[TB] FAIL reset_regs got=%h want=CC=50 others 0", dutRegs());
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy got=%b want=0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || bad !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_done_idle cycle=%0d got=%b%b want=00", i, done, bad);
      end
    end
  endtask

  task automatic test_tfr();
    loadReg(4'h1, 16'h1234);
    runXfer(8'h3F, 8'h12);
    compared++;
    if (y !== 16'h1234 || x !== 16'h1234) begin
      mismatched++;
      $display("[TB] FAIL tfr_x_to_y got x=%h y=%h want x=1234 y=1234", x, y);
    end
  endtask

  task automatic test_exg();
    loadReg(4'h1, 16'hAAAA);
    loadReg(4'h3, 16'h5555);
    runXfer(8'h3E, 8'h13);
    compared++;
    if (x !== 16'h5555 || u !== 16'hAAAA) begin
      mismatched++;
      $display("[TB] FAIL exg_x_u got x=%h u=%h want x=5555 u=aaaa", x, u);
    end
  endtask

  task automatic test_mixed_width();
    loadReg(4'h8, 16'h0012);
    loadReg(4'h9, 16'h0034);
    runXfer(8'h3E, 8'h08);
    compared++;
    if (a !== 8'hFF || b !== 8'h12) begin
      mismatched++;
      $display("[TB] FAIL exg_d_a got a=%h b=%h want a=ff b=12", a, b);
    end
  endtask

  task automatic test_invalid();
    runXfer(8'h3F, 8'h6A);
    compared++;
    if (cc !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL invalid_src_cc got=%h want=00", cc);
    end
  endtask

  task automatic test_same_reg_and_load_start();
    loadReg(4'h4, 16'hBEEF);
    runXfer(8'h3E, 8'h44);
    // load and start in the same cycle: LATCH must see the loaded PC
    ld_we = 1'b1; ld_sel = 4'h5; ld_data = 16'hC0DE;
    mWrite(4'h5, 16'hC0DE);
    runXfer(8'h3F, 8'h52);
    ld_we = 1'b0;
    compared++;
    if (y !== 16'hC0DE) begin
      mismatched++;
      $display("[TB] FAIL load_with_start got y=%h want c0de", y);
    end
  endtask

  task automatic test_random();
    logic [3:0] codes [0:11];
    codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'hF};
    for (int i = 0; i < 8; i++) begin
      loadReg(codes[$urandom_range(0, 9)], 16'($urandom));
      runXfer(($urandom_range(0, 1) == 1) ? 8'h3E : 8'h3F,
              {codes[$urandom_range(0, 11)], codes[$urandom_range(0, 11)]});
    end
  endtask

  task automatic test_reset_mid_xfer();
    loadReg(4'h1, 16'hAAAA);
    loadReg(4'h3, 16'h5555);
    start = 1'b1; op = 8'h3E; postbyte = 8'h13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    mReset();
    #1;
    compared++;
    if (dutRegs() !== modelRegs() || busy !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_xfer got=%h busy=%b done=%b want=%h busy=0 done=0",
               dutRegs(), busy, done, modelRegs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    loadReg(4'h2, 16'h7777);
    runXfer(8'h3F, 8'h21);
    compared++;
    if (x !== 16'h7777) begin
      mismatched++;
      $display("[TB] FAIL xfer_after_reset got x=%h want 7777", x);
    end
  endtask

`ifdef JTKCPU_XFER_DBG_EN
  task automatic test_debug();
    compared++;
    if (xfer_cnt !== 16'(mCnt) || last_pb !== mLastPb) begin
      mismatched++;
      $display("[TB] FAIL debug_regs got cnt=%0d pb=%h want cnt=%0d pb=%h",
               xfer_cnt, last_pb, mCnt, mLastPb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tfr();
    test_exg();
    test_mixed_width();
    test_invalid();
    test_same_reg_and_load_start();
    test_random();
    test_reset_mid_xfer();
`ifdef JTKCPU_XFER_DBG_EN
    test_debug();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
